// File: rtl/gcd_requester.sv
// gcd_requester: hands one operand pair to an external GCD unit over a
// start/done level handshake and presents the result, or a timeout error, downstream.
//
// state   | meaning
// IDLE    | ready to accept a new operand pair
// RUN     | gcd_start high, waiting for gcd_done or timeout
// RELEASE | gcd_start low, waiting for gcd_done to fall
// RESP    | result presented, held until rsp_ready
module gcd_requester #(
    parameter int W       = 16,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    output logic         gcd_start,
    output logic [W-1:0] gcd_inA,
    output logic [W-1:0] gcd_inB,
    input  logic         gcd_done,
    input  logic [W-1:0] gcd_outR,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_err,
    output logic         busy
);
    typedef enum logic [1:0] {IDLE, RUN, RELEASE, RESP} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t       state, state_nxt;
    logic [7:0]   tmo_cnt;
    logic [W-1:0] op_a, op_b, rsp_data_q;
    logic         rsp_err_q;
    logic         tmo_hit;

    assign tmo_hit = (tmo_cnt == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        gcd_start = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) state_nxt = RUN;
            end
            RUN: begin
                gcd_start = 1'b1;
                // done wins over a timeout landing on the same edge
                if (gcd_done || tmo_hit) state_nxt = RELEASE;
            end
            RELEASE: begin
                if (!gcd_done) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_a       <= '0;
            op_b       <= '0;
            tmo_cnt    <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_a    <= req_a;
                        op_b    <= req_b;
                        tmo_cnt <= '0;
                    end
                end
                RUN: begin
                    if (gcd_done) begin
                        rsp_data_q <= gcd_outR;
                        rsp_err_q  <= 1'b0;
                    end else if (tmo_hit) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gcd_inA  = op_a;
    assign gcd_inB  = op_b;
    assign rsp_data = rsp_data_q;
    assign rsp_err  = rsp_err_q;

endmodule

// File: tb/tb_gcd_requester.sv
// Bench for gcd_requester: behavioural GCD unit, table of directed vectors,
// reset and queued-request sequences, then randomized transactions.
module tb_gcd_requester;
    localparam int W       = 16;
    localparam int TIMEOUT = 255;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid, req_ready;
    logic [W-1:0] req_a, req_b;
    logic         gcd_start, gcd_done;
    logic [W-1:0] gcd_inA, gcd_inB, gcd_outR;
    logic         rsp_valid, rsp_ready, rsp_err, busy;
    logic [W-1:0] rsp_data;

    int n_cmp = 0;
    int n_err = 0;

    gcd_requester #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .gcd_start(gcd_start), .gcd_inA(gcd_inA), .gcd_inB(gcd_inB),
        .gcd_done(gcd_done), .gcd_outR(gcd_outR),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x_in, input logic [W-1:0] y_in);
        logic [W-1:0] x, y, t;
        x = x_in;
        y = y_in;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // GCD unit model: done rises model_lat edges after start is seen, stays
    // high model_hold extra edges after start drops.
    int model_lat  = 0;
    int model_hold = 0;
    bit model_never = 1'b0;
    int m_cnt, m_hold;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            gcd_done <= 1'b0;
            gcd_outR <= '0;
            m_cnt    <= 0;
            m_hold   <= 0;
        end else if (gcd_start) begin
            if (!gcd_done) begin
                if (!model_never && m_cnt >= model_lat) begin
                    gcd_done <= 1'b1;
                    gcd_outR <= ref_gcd(gcd_inA, gcd_inB);
                    m_hold   <= model_hold;
                end else begin
                    m_cnt <= m_cnt + 1;
                end
            end
        end else begin
            if (gcd_done && m_hold > 0) m_hold <= m_hold - 1;
            else begin
                gcd_done <= 1'b0;
                m_cnt    <= 0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0d required %0d", name, act, exp);
        end
    endtask

    // One transaction. Junk operands with req_valid high are driven while busy
    // to show they are ignored.
    task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                           input bit never, input int hold, input int bp, input bit pre,
                           output logic [W-1:0] d, output logic e,
                           output int starts, output int rel);
        int op_bad;
        bit got;
        model_lat   = lat;
        model_never = never;
        model_hold  = hold;
        if (!pre) begin
            @(negedge clk);
            req_a = a; req_b = b; req_valid = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check("start_on_accept", {gcd_start, busy, req_ready}, 3'b110);
        req_a = W'($urandom); req_b = W'($urandom);
        starts = 0; rel = 0; op_bad = 0; got = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (rsp_valid) begin
                got = 1'b1;
                break;
            end
            if (gcd_start) begin
                starts++;
                if (gcd_inA !== a || gcd_inB !== b) op_bad++;
            end else begin
                rel++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        check("rsp_valid_seen", 64'(got), 64'd1);
        check("operands_stable_run", 64'(op_bad), 64'd0);
        d = rsp_data;
        e = rsp_err;
        for (int j = 0; j < bp; j++) begin
            @(negedge clk);
            check("bp_hold", {rsp_valid, req_ready, rsp_err, rsp_data}, {1'b1, 1'b0, e, d});
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("back_to_idle", {req_ready, busy, rsp_valid}, 3'b100);
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        int           lat;
        bit           never;
        int           hold;
        int           bp;
        logic [W-1:0] d;
        bit           e;
        int           starts;
        int           rel;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [W-1:0] d, ra, rb, exp_d;
        logic         e, exp_e;
        int           starts, rel, lat, hold, bp, k, got, idle_busy;
        bit           never;
        logic [W-1:0] qa[3], qb[3], qr[3];

        tbl[0] = '{16'd48,    16'd18,    2,   1'b0, 0, 10, 16'd6,     1'b0, 4,   2};
        tbl[1] = '{16'd7,     16'd0,     0,   1'b0, 0, 0,  16'd7,     1'b0, 2,   2};
        tbl[2] = '{16'd0,     16'd9,     1,   1'b0, 1, 1,  16'd9,     1'b0, 3,   3};
        tbl[3] = '{16'd0,     16'd0,     0,   1'b0, 0, 0,  16'd0,     1'b0, 2,   2};
        tbl[4] = '{16'd12,    16'd8,     3,   1'b0, 2, 2,  16'd4,     1'b0, 5,   4};
        tbl[5] = '{16'hFFFF,  16'hFFFF,  0,   1'b0, 0, 0,  16'hFFFF,  1'b0, 2,   2};
        tbl[6] = '{16'd17,    16'd5,     253, 1'b0, 0, 0,  16'd1,     1'b0, 255, 2};
        tbl[7] = '{16'd17,    16'd5,     254, 1'b0, 0, 0,  16'd0,     1'b1, 255, 2};
        tbl[8] = '{16'd48,    16'd18,    0,   1'b1, 0, 3,  16'd0,     1'b1, 255, 1};
        tbl[9] = '{16'd35,    16'd14,    0,   1'b0, 4, 0,  16'd7,     1'b0, 2,   6};

        rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        #2;
        check("reset_ctrl", {req_ready, busy, gcd_start, rsp_valid, rsp_err}, 5'b10000);
        check("reset_data", {rsp_data, gcd_inA, gcd_inB}, 48'd0);
        @(negedge clk);
        rst = 1'b1;

        foreach (tbl[i]) begin
            run_txn(tbl[i].a, tbl[i].b, tbl[i].lat, tbl[i].never, tbl[i].hold, tbl[i].bp,
                    1'b0, d, e, starts, rel);
            check($sformatf("vec%0d_data", i), 64'(d), 64'(tbl[i].d));
            check($sformatf("vec%0d_err", i), 64'(e), 64'(tbl[i].e));
            check($sformatf("vec%0d_start_cycles", i), 64'(starts), 64'(tbl[i].starts));
            check($sformatf("vec%0d_release_cycles", i), 64'(rel), 64'(tbl[i].rel));
        end

        // asynchronous reset three cycles into RUN, then first-edge accept
        model_lat = 50; model_never = 1'b0; model_hold = 0;
        @(negedge clk);
        req_a = 16'd48; req_b = 16'd18; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        check("async_rst_ctrl", {gcd_start, busy, req_ready, rsp_valid}, 4'b0010);
        check("async_rst_data", {rsp_err, rsp_data, gcd_inA}, 33'd0);
        req_a = 16'd12; req_b = 16'd8; req_valid = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        run_txn(16'd12, 16'd8, 1, 1'b0, 0, 0, 1'b1, d, e, starts, rel);
        check("after_rst_data", 64'(d), 64'd4);
        check("after_rst_err", 64'(e), 64'd0);

        // queued pairs with req_valid held and rsp_ready tied high
        qa = '{16'd48, 16'd35, 16'd17};
        qb = '{16'd18, 16'd14, 16'd5};
        qr = '{16'd6,  16'd7,  16'd1};
        model_lat = 1; model_hold = 0;
        rsp_ready = 1'b1;
        k = 0; got = 0;
        for (int cyc = 0; cyc < 3000 && got < 3; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                check($sformatf("queued_rsp%0d", got), {rsp_err, rsp_data}, {1'b0, qr[got]});
                got++;
                if (got == 3) req_valid = 1'b0;
            end
            if (req_ready && k < 3) begin
                req_a = qa[k]; req_b = qb[k]; req_valid = 1'b1;
                k++;
            end
        end
        check("queued_count", 64'(got), 64'd3);
        idle_busy = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy || rsp_valid) idle_busy++;
        end
        check("queued_no_extra", 64'(idle_busy), 64'd0);
        rsp_ready = 1'b0;

        // randomized transactions against the reference rules
        for (int n = 0; n < 30; n++) begin
            ra    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            rb    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 20)) : W'($urandom);
            lat   = $urandom_range(0, 6);
            never = ($urandom_range(0, 9) == 0);
            hold  = $urandom_range(0, 3);
            bp    = $urandom_range(0, 3);
            run_txn(ra, rb, lat, never, hold, bp, 1'b0, d, e, starts, rel);
            exp_e = never || (lat + 2 > TIMEOUT);
            exp_d = exp_e ? '0 : ref_gcd(ra, rb);
            check($sformatf("rand%0d_data", n), {e, d}, {exp_e, exp_d});
            check($sformatf("rand%0d_start_cycles", n), 64'(starts),
                  exp_e ? 64'(TIMEOUT) : 64'(lat + 2));
            check($sformatf("rand%0d_release_cycles", n), 64'(rel),
                  (!never && lat + 1 <= TIMEOUT) ? 64'(hold + 2) : 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gcd_requester.md
GCD_REQUESTER -- requirements
Module: gcd_requester

Interface
REQ-001 Parameter W, default 16: operand and result width in bits.
REQ-002 Parameter TIMEOUT, default 255: maximum RUN cycles awaiting gcd_done, 1..255.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 req_valid  input  1  upstream operand pair valid.
REQ-006 req_ready  output  1  block accepts operand pair.
REQ-007 req_a, req_b  input  W  upstream operands.
REQ-008 gcd_start  output  1  start level to GCD unit.
REQ-009 gcd_inA, gcd_inB  output  W  operands to GCD unit.
REQ-010 gcd_done  input  1  done level from GCD unit.
REQ-011 gcd_outR  input  W  result from GCD unit.
REQ-012 rsp_valid  output  1  result available downstream.
REQ-013 rsp_ready  input  1  downstream accepts result.
REQ-014 rsp_data  output  W  captured result.
REQ-015 rsp_err  output  1  1 = timeout, rsp_data invalid (0).
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 FSM states SHALL be IDLE, RUN, RELEASE, RESP; all outputs decoded from state and registers only (Moore).
REQ-018 IDLE: req_ready=1, gcd_start=0; on req_valid=1 at edge, latch req_a/req_b into operand registers, go RUN.
REQ-019 gcd_inA/gcd_inB SHALL be driven from operand registers, stable from RUN entry until next IDLE accept.
REQ-020 RUN: gcd_start=1 every cycle; 8-bit timeout counter cleared on RUN entry, +1 per RUN cycle with gcd_done=0.
REQ-021 RUN, gcd_done=1 at edge: capture gcd_outR into rsp_data, rsp_err=0, go RELEASE; done takes priority over timeout in same cycle.
REQ-022 RUN, gcd_done=0 and counter==TIMEOUT-1 at edge: rsp_data=0, rsp_err=1, go RELEASE.
REQ-023 RELEASE: gcd_start=0; stay while gcd_done=1; go RESP at first edge with gcd_done=0.
REQ-024 RESP: rsp_valid=1, rsp_data/rsp_err held; on rsp_ready=1 at edge go IDLE.
REQ-025 rsp_valid SHALL NOT drop and rsp_data SHALL NOT change while rsp_ready=0.
REQ-026 req_ready SHALL be 0 outside IDLE; req_valid outside IDLE ignored, no operand update.
REQ-027 Latency: accept at edge N -> gcd_start=1 from N; rsp_valid=1 two edges after the edge sampling gcd_done=1, if done falls immediately after start drops.
REQ-028 Operands passed unmodified, incl. zero values; no arithmetic performed in this block.
REQ-029 Back-to-back: RESP->IDLE transition then new accept; minimum one IDLE cycle between requests.

Reset
REQ-030 rst=0 SHALL immediately, without clock, force state IDLE, gcd_start=0, rsp_valid=0, rsp_err=0, busy=0, rsp_data=0, operand registers=0, counter=0; req_ready=1.
REQ-031 Reset mid-RUN or mid-RESP SHALL discard the operation; no rsp_valid pulse after release of rst.
REQ-032 First accept possible at first rising edge after rst returns to 1.

Verification
REQ-033 req (48,18) with behavioural GCD model -> gcd_inA=48, gcd_inB=18 during RUN, rsp_valid with rsp_data=6, rsp_err=0.
REQ-034 req (7,0) -> rsp_data=7, rsp_err=0; req (0,9) -> rsp_data=9.
REQ-035 Model never asserts gcd_done, TIMEOUT=255 -> gcd_start high exactly 255 cycles, then rsp_valid, rsp_err=1, rsp_data=0.
REQ-036 rsp_ready held 0 for 10 cycles in RESP -> rsp_valid and rsp_data=6 stable all 10 cycles, req_ready=0, return to IDLE on first rsp_ready=1.
REQ-037 rst=0 asserted 3 cycles into RUN -> gcd_start=0 and busy=0 same cycle, no later response; then req (12,8) -> rsp_data=4.
REQ-038 req_valid held high with 3 queued pairs (48,18),(35,14),(17,5) and rsp_ready=1 -> responses 6,7,1 in order, each pair accepted once.
